// File: rtl/alu_pkg.sv
// Shared encodings and widths for the 6-bit signed ALU (RTL and bench).
package alu_pkg;

  localparam int unsigned OPND_W = 5;
  localparam int unsigned RES_W  = 6;

  // Mode is {b_en, a_en}
  typedef enum logic [1:0] {
    MODE_IDLE = 2'b00,
    MODE_A    = 2'b01,
    MODE_B01  = 2'b10,
    MODE_B11  = 2'b11
  } OP_MODE_t;

  typedef enum logic {
    ALU_DIS = 1'b0,
    ALU_ENA = 1'b1
  } ALU_EN_STATE_t;

  typedef enum logic [2:0] {
    A_ADD  = 3'd0,
    A_SUB  = 3'd1,
    A_XOR  = 3'd2,
    A_AND1 = 3'd3,
    A_AND2 = 3'd4,
    A_OR   = 3'd5,
    A_XNOR = 3'd6,
    A_NULL = 3'd7
  } OP_A_t;

  typedef enum logic [1:0] {
    B01_NAND = 2'd0,
    B01_ADD1 = 2'd1,
    B01_ADD2 = 2'd2,
    B01_NULL = 2'd3
  } OP_B01_t;

  typedef enum logic [1:0] {
    B11_XOR     = 2'd0,
    B11_XNOR    = 2'd1,
    B11_A_SUB_1 = 2'd2,
    B11_B_ADD_2 = 2'd3
  } OP_B11_t;

  // What an issued cycle does to the output stage
  typedef enum logic [1:0] {
    KIND_OFF  = 2'd0,
    KIND_IDLE = 2'd1,
    KIND_OP   = 2'd2
  } op_kind_t;

  function automatic logic [RES_W-1:0] sext(input logic [OPND_W-1:0] x);
    return {{(RES_W - OPND_W){x[OPND_W-1]}}, x};
  endfunction

  function automatic OP_MODE_t decode_mode(input logic a_en, input logic b_en);
    return OP_MODE_t'({b_en, a_en});
  endfunction

endpackage

// File: rtl/alu_if.sv
// ALU bus between the driver (master) and the ALU core (slave).
interface alu_if #(
  parameter int unsigned CNT_W = 8
) ();

  logic                       ALU_en;
  logic                       a_en;
  logic                       b_en;
  logic [2:0]                 a_op;
  logic [1:0]                 b_op;
  logic [alu_pkg::OPND_W-1:0] A;
  logic [alu_pkg::OPND_W-1:0] B;
  logic [alu_pkg::RES_W-1:0]  C;
  logic                       c_valid;
  logic                       null_op;
  logic [CNT_W-1:0]           op_cnt;

  modport master (
    output ALU_en, a_en, b_en, a_op, b_op, A, B,
    input  C, c_valid, null_op, op_cnt
  );

  modport slave (
    input  ALU_en, a_en, b_en, a_op, b_op, A, B,
    output C, c_valid, null_op, op_cnt
  );

endinterface

// File: rtl/alu_exec.sv
// Combinational mode decode and compute on sign-extended operands.
module alu_exec
  import alu_pkg::*;
(
  input  logic              i_a_en,
  input  logic              i_b_en,
  input  logic [2:0]        i_a_op,
  input  logic [1:0]        i_b_op,
  input  logic [OPND_W-1:0] i_a,
  input  logic [OPND_W-1:0] i_b,
  output logic [RES_W-1:0]  o_result,
  output logic              o_is_null,
  output logic              o_is_idle
);

  logic [RES_W-1:0] w_a;
  logic [RES_W-1:0] w_b;
  OP_MODE_t         w_mode;

  assign w_a    = sext(i_a);
  assign w_b    = sext(i_b);
  assign w_mode = decode_mode(i_a_en, i_b_en);

  // Select the result for the decoded mode/opcode; arithmetic wraps mod 64
  always_comb begin
    o_result  = '0;
    o_is_null = 1'b0;
    o_is_idle = 1'b0;
    unique case (w_mode)
      MODE_IDLE: o_is_idle = 1'b1;
      MODE_A: begin
        unique case (OP_A_t'(i_a_op))
          A_ADD:          o_result = w_a + w_b;
          A_SUB:          o_result = w_a - w_b;
          A_XOR:          o_result = w_a ^ w_b;
          A_AND1, A_AND2: o_result = w_a & w_b;
          A_OR:           o_result = w_a | w_b;
          A_XNOR:         o_result = ~(w_a ^ w_b);
          A_NULL:         o_is_null = 1'b1;
        endcase
      end
      MODE_B01: begin
        unique case (OP_B01_t'(i_b_op))
          B01_NAND:           o_result = ~(w_a & w_b);
          B01_ADD1, B01_ADD2: o_result = w_a + w_b;
          B01_NULL:           o_is_null = 1'b1;
        endcase
      end
      MODE_B11: begin
        unique case (OP_B11_t'(i_b_op))
          B11_XOR:     o_result = w_a ^ w_b;
          B11_XNOR:    o_result = ~(w_a ^ w_b);
          B11_A_SUB_1: o_result = w_a - RES_W'(1);
          B11_B_ADD_2: o_result = w_b + RES_W'(2);
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_core.sv
// ALU core: optional pipeline stage, registered result, valid/null flags and
// a saturating count of valid results.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned LATENCY = 1,  // 1 or 2; anything other than 2 behaves as 1
  parameter int unsigned CNT_W   = 8
) (
  input logic clk,
  input logic rst,
  alu_if.slave bus
);

  logic [RES_W-1:0] w_result;
  logic             w_is_null;
  logic             w_is_idle;
  op_kind_t         w_kind;
  op_kind_t         w_st_kind;
  logic [RES_W-1:0] w_st_res;
  logic             w_st_null;

  logic [RES_W-1:0] r_c;
  logic             r_valid;
  logic             r_null;
  logic [CNT_W-1:0] r_op_cnt;

  alu_exec u_exec (
    .i_a_en   (bus.a_en),
    .i_b_en   (bus.b_en),
    .i_a_op   (bus.a_op),
    .i_b_op   (bus.b_op),
    .i_a      (bus.A),
    .i_b      (bus.B),
    .o_result (w_result),
    .o_is_null(w_is_null),
    .o_is_idle(w_is_idle)
  );

  assign w_kind = !bus.ALU_en ? KIND_OFF : (w_is_idle ? KIND_IDLE : KIND_OP);

  if (LATENCY == 2) begin : g_lat2
    op_kind_t         r_s1_kind;
    logic [RES_W-1:0] r_s1_res;
    logic             r_s1_null;

    // Stage 1; reset flushes to idle so no result emerges after reset
    always_ff @(posedge clk) begin
      if (rst) begin
        r_s1_kind <= KIND_IDLE;
        r_s1_res  <= '0;
        r_s1_null <= 1'b0;
      end else begin
        r_s1_kind <= w_kind;
        r_s1_res  <= w_result;
        r_s1_null <= w_is_null;
      end
    end

    assign w_st_kind = r_s1_kind;
    assign w_st_res  = r_s1_res;
    assign w_st_null = r_s1_null;
  end else begin : g_lat1
    assign w_st_kind = w_kind;
    assign w_st_res  = w_result;
    assign w_st_null = w_is_null;
  end

  // Output stage: disable clears C, idle holds C, ops load C and count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_c      <= '0;
      r_valid  <= 1'b0;
      r_null   <= 1'b0;
      r_op_cnt <= '0;
    end else begin
      case (w_st_kind)
        KIND_OFF: begin
          r_c     <= '0;
          r_valid <= 1'b0;
          r_null  <= 1'b0;
        end
        KIND_OP: begin
          r_c     <= w_st_res;
          r_valid <= 1'b1;
          r_null  <= w_st_null;
          if (r_op_cnt != {CNT_W{1'b1}}) begin
            r_op_cnt <= r_op_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_null  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.C       = r_c;
  assign bus.c_valid = r_valid;
  assign bus.null_op = r_null;
  assign bus.op_cnt  = r_op_cnt;

endmodule

// File: tb/tb_alu_core.sv
// Bench for alu_core: three instances (LATENCY=1/CNT_W=8, LATENCY=1/CNT_W=4,
// LATENCY=2/CNT_W=8) share one stimulus and are checked against an integer model.
module tb_alu_core;
  import alu_pkg::*;

  logic clk;
  logic rst;
  logic en, aen, ben;
  logic [2:0] aop;
  logic [1:0] bop;
  logic [4:0] a, b;

  int checks = 0;
  int errors = 0;

  alu_if #(.CNT_W(8)) if0 ();
  alu_if #(.CNT_W(4)) ifs ();
  alu_if #(.CNT_W(8)) if2 ();

  assign if0.ALU_en = en;  assign if0.a_en = aen;  assign if0.b_en = ben;
  assign if0.a_op = aop;   assign if0.b_op = bop;  assign if0.A = a;  assign if0.B = b;
  assign ifs.ALU_en = en;  assign ifs.a_en = aen;  assign ifs.b_en = ben;
  assign ifs.a_op = aop;   assign ifs.b_op = bop;  assign ifs.A = a;  assign ifs.B = b;
  assign if2.ALU_en = en;  assign if2.a_en = aen;  assign if2.b_en = ben;
  assign if2.a_op = aop;   assign if2.b_op = bop;  assign if2.A = a;  assign if2.B = b;

  alu_core #(.LATENCY(1), .CNT_W(8)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  alu_core #(.LATENCY(1), .CNT_W(4)) u_duts (.clk(clk), .rst(rst), .bus(ifs));
  alu_core #(.LATENCY(2), .CNT_W(8)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {int k; int r; bit n;} ev_t;
  ev_t q2[$];
  logic [5:0] m1_c, m2_c;
  bit m1_v, m1_n, m2_v, m2_n;
  int m1_cnt, ms_cnt, m2_cnt;

  // kind: 0 disabled, 1 idle, 2 operation; res is the 6-bit pattern
  function automatic void ref_op(input bit en_, aen_, ben_, input int aop_, bop_, a_, b_,
                                 output int kind, output int res, output bit nul);
    int sa, sb;
    sa = (a_ >= 16) ? a_ - 32 : a_;
    sb = (b_ >= 16) ? b_ - 32 : b_;
    res = 0;
    nul = 0;
    if (!en_) kind = 0;
    else if (!aen_ && !ben_) kind = 1;
    else begin
      kind = 2;
      if (aen_ && !ben_) begin
        case (aop_)
          0: res = sa + sb;
          1: res = sa - sb;
          2: res = sa ^ sb;
          3, 4: res = sa & sb;
          5: res = sa | sb;
          6: res = ~(sa ^ sb);
          default: nul = 1;
        endcase
      end else if (!aen_) begin
        case (bop_)
          0: res = ~(sa & sb);
          1, 2: res = sa + sb;
          default: nul = 1;
        endcase
      end else begin
        case (bop_)
          0: res = sa ^ sb;
          1: res = ~(sa ^ sb);
          2: res = sa - 1;
          default: res = sb + 2;
        endcase
      end
    end
    res = res & 63;
  endfunction

  always @(posedge clk) begin
    int k, r;
    bit n;
    ev_t e;
    if (rst) begin
      m1_c = 0; m1_v = 0; m1_n = 0; m1_cnt = 0; ms_cnt = 0;
      m2_c = 0; m2_v = 0; m2_n = 0; m2_cnt = 0;
      q2.delete();
    end else begin
      ref_op(en, aen, ben, int'(aop), int'(bop), int'(a), int'(b), k, r, n);
      m1_v = (k == 2);
      m1_n = (k == 2) && n;
      if (k == 0) m1_c = 0;
      if (k == 2) begin
        m1_c = 6'(r);
        if (m1_cnt < 255) m1_cnt++;
        if (ms_cnt < 15) ms_cnt++;
      end
      q2.push_back('{k, r, n});
      m2_v = 0;
      m2_n = 0;
      if (q2.size() > 1) begin
        e = q2.pop_front();
        m2_v = (e.k == 2);
        m2_n = (e.k == 2) && e.n;
        if (e.k == 0) m2_c = 0;
        if (e.k == 2) begin
          m2_c = 6'(e.r);
          if (m2_cnt < 255) m2_cnt++;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_in(input bit en_, aen_, ben_, input int aop_, bop_, a_, b_);
    en = en_; aen = aen_; ben = ben_;
    aop = 3'(aop_); bop = 2'(bop_); a = 5'(a_); b = 5'(b_);
  endtask

  task automatic rand_in();
    en = 1'($urandom); aen = 1'($urandom); ben = 1'($urandom);
    aop = 3'($urandom); bop = 2'($urandom); a = 5'($urandom); b = 5'($urandom);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    rand_in();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (if0.C !== 6'd0) begin errors++; $display("FAIL reset_C: got %0d expected 0", if0.C); end
      checks++; if (if0.c_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", if0.c_valid); end
      checks++; if (if0.op_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", if0.op_cnt); end
      checks++; if (if2.C !== 6'd0 || if2.c_valid !== 1'b0) begin errors++; $display("FAIL reset_lat2: got C=%0d v=%0b expected C=0 v=0", if2.C, if2.c_valid); end
      rand_in();
    end
    rst = 1'b0;
    set_in(1, 1, 0, int'(A_ADD), 0, 1, 2);
    @(negedge clk);
    checks++; if (if0.C !== 6'd3 || if0.c_valid !== 1'b1) begin errors++; $display("FAIL first_op: got C=%0d v=%0b expected C=3 v=1", if0.C, if0.c_valid); end
    checks++; if (if0.op_cnt !== 8'd1) begin errors++; $display("FAIL first_cnt: got %0d expected 1", if0.op_cnt); end
    set_in(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_mode_a();
    int exp_c[8] = '{-1, -31, -1, 0, 0, -1, 0, 0};
    do_reset();
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++; if (int'($signed(if0.C)) !== exp_c[i-1]) begin errors++; $display("FAIL mode_a_C[%0d]: got %0d expected %0d", i-1, $signed(if0.C), exp_c[i-1]); end
        checks++; if (if0.C !== m1_c) begin errors++; $display("FAIL mode_a_model[%0d]: got %0d expected %0d", i-1, if0.C, m1_c); end
        checks++; if (if0.c_valid !== 1'b1) begin errors++; $display("FAIL mode_a_valid[%0d]: got %0b expected 1", i-1, if0.c_valid); end
        checks++; if (if0.null_op !== (i-1 == int'(A_NULL))) begin errors++; $display("FAIL mode_a_null[%0d]: got %0b expected %0b", i-1, if0.null_op, (i-1 == 7)); end
      end
      if (i < 8) set_in(1, 1, 0, i, 0, -16, 15);
      else set_in(1, 0, 0, 0, 0, 0, 0);
    end
    checks++; if (if0.op_cnt !== 8'd8) begin errors++; $display("FAIL mode_a_cnt: got %0d expected 8", if0.op_cnt); end
  endtask

  task automatic test_mode_b();
    int exp_c[8] = '{-6, 4, 4, 0, -1, 0, -17, 17};
    do_reset();
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++; if (int'($signed(if0.C)) !== exp_c[i-1]) begin errors++; $display("FAIL mode_b_C[%0d]: got %0d expected %0d", i-1, $signed(if0.C), exp_c[i-1]); end
        checks++; if (if0.c_valid !== 1'b1 || if0.null_op !== (i-1 == 3)) begin errors++; $display("FAIL mode_b_flags[%0d]: got v=%0b n=%0b expected v=1 n=%0b", i-1, if0.c_valid, if0.null_op, (i-1 == 3)); end
      end
      if (i < 4) set_in(1, 0, 1, 0, i, 7, -3);
      else if (i < 8) set_in(1, 1, 1, 0, i - 4, -16, 15);
      else set_in(0, 0, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic test_idle_disable();
    do_reset();
    @(negedge clk);
    set_in(1, 1, 0, int'(A_ADD), 0, 5, 6);
    @(negedge clk);
    checks++; if (if0.C !== 6'd11 || if0.c_valid !== 1'b1) begin errors++; $display("FAIL add_5_6: got C=%0d v=%0b expected C=11 v=1", if0.C, if0.c_valid); end
    set_in(1, 0, 0, $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 31));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (if0.C !== 6'd11 || if0.c_valid !== 1'b0 || if0.null_op !== 1'b0) begin errors++; $display("FAIL idle_hold[%0d]: got C=%0d v=%0b n=%0b expected C=11 v=0 n=0", i, if0.C, if0.c_valid, if0.null_op); end
      if (i < 2) set_in(1, 0, 0, $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 31));
      else set_in(0, 1, 1, $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 31));
    end
    @(negedge clk);
    checks++; if (if0.C !== 6'd0 || if0.c_valid !== 1'b0) begin errors++; $display("FAIL disable_clear: got C=%0d v=%0b expected C=0 v=0", if0.C, if0.c_valid); end
    checks++; if (if0.op_cnt !== 8'd1) begin errors++; $display("FAIL disable_cnt: got %0d expected 1", if0.op_cnt); end
    set_in(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_saturation();
    int m;
    do_reset();
    for (int i = 0; i <= 20; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++; if (ifs.op_cnt !== 4'((i > 15) ? 15 : i)) begin errors++; $display("FAIL sat_cnt[%0d]: got %0d expected %0d", i, ifs.op_cnt, (i > 15) ? 15 : i); end
        checks++; if (ifs.C !== m1_c || ifs.c_valid !== 1'b1) begin errors++; $display("FAIL sat_C[%0d]: got C=%0d v=%0b expected C=%0d v=1", i, ifs.C, ifs.c_valid, m1_c); end
      end
      m = $urandom_range(1, 3);
      if (i < 20) set_in(1, m[0], m[1], $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 31));
      else set_in(0, 0, 0, 0, 0, 0, 0);
    end
    checks++; if (if0.op_cnt !== 8'd20) begin errors++; $display("FAIL unsat_cnt: got %0d expected 20", if0.op_cnt); end
  endtask

  task automatic test_back_to_back_random();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      checks++; if (if0.C !== m1_c || if0.c_valid !== m1_v || if0.null_op !== m1_n) begin errors++; $display("FAIL rnd_l1[%0d]: got C=%0d v=%0b n=%0b expected C=%0d v=%0b n=%0b", i, if0.C, if0.c_valid, if0.null_op, m1_c, m1_v, m1_n); end
      checks++; if (int'(if0.op_cnt) !== m1_cnt || int'(ifs.op_cnt) !== ms_cnt) begin errors++; $display("FAIL rnd_cnt[%0d]: got %0d/%0d expected %0d/%0d", i, if0.op_cnt, ifs.op_cnt, m1_cnt, ms_cnt); end
      checks++; if (if2.C !== m2_c || if2.c_valid !== m2_v || if2.null_op !== m2_n || int'(if2.op_cnt) !== m2_cnt) begin errors++; $display("FAIL rnd_l2[%0d]: got C=%0d v=%0b n=%0b cnt=%0d expected C=%0d v=%0b n=%0b cnt=%0d", i, if2.C, if2.c_valid, if2.null_op, if2.op_cnt, m2_c, m2_v, m2_n, m2_cnt); end
      rand_in();
      if ($urandom_range(0, 4) != 0) en = 1'b1;
      rst = ($urandom_range(0, 39) == 0);
    end
    rst = 1'b0;
  endtask

  task automatic test_lat2_reset();
    do_reset();
    @(negedge clk);
    set_in(1, 1, 0, int'(A_ADD), 0, 1, 1);
    @(negedge clk);
    checks++; if (if0.C !== 6'd2) begin errors++; $display("FAIL l1_add_1_1: got %0d expected 2", if0.C); end
    checks++; if (if2.c_valid !== 1'b0 || if2.C !== 6'd0) begin errors++; $display("FAIL l2_in_flight: got C=%0d v=%0b expected C=0 v=0", if2.C, if2.c_valid); end
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (if2.c_valid !== 1'b0 || if2.C !== 6'd0 || if2.op_cnt !== 8'd0) begin errors++; $display("FAIL l2_flush[%0d]: got C=%0d v=%0b cnt=%0d expected C=0 v=0 cnt=0", i, if2.C, if2.c_valid, if2.op_cnt); end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_mode_a();
    test_mode_b();
    test_idle_disable();
    test_saturation();
    test_back_to_back_random();
    test_lat2_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
